// File: rtl/vga_timing_controller.sv
// VGA scan timing: horizontal/vertical counters, pixel-bus strobes for the engine,
// and a one-stage output register aligning colour with HSYNC/VSYNC at the pins.
module vga_timing_controller #(
  parameter int H_CNT_WID = 10,
  parameter int V_CNT_WID = 10,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_en,
  output logic                 pixIf_NEXT_FRAME,
  output logic                 pixIf_H_BLANKING,
  output logic [H_CNT_WID-1:0] pixIf_H_CNT,
  output logic [V_CNT_WID-1:0] pixIf_next_V_CNT,
  input  logic [3:0]           pixIf_r,
  input  logic [3:0]           pixIf_g,
  input  logic [3:0]           pixIf_b,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 HSYNC,
  output logic                 VSYNC
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [H_CNT_WID-1:0] H_LAST   = H_CNT_WID'(H_TOTAL - 1);
  localparam logic [H_CNT_WID-1:0] H_VIS    = H_CNT_WID'(H_VISIBLE);
  localparam logic [H_CNT_WID-1:0] HS_START = H_CNT_WID'(H_VISIBLE + H_FRONT);
  localparam logic [H_CNT_WID-1:0] HS_END   = H_CNT_WID'(H_VISIBLE + H_FRONT + H_SYNC);

  localparam logic [V_CNT_WID-1:0] V_LAST     = V_CNT_WID'(V_TOTAL - 1);
  localparam logic [V_CNT_WID-1:0] V_VIS      = V_CNT_WID'(V_VISIBLE);
  localparam logic [V_CNT_WID-1:0] V_VIS_LAST = V_CNT_WID'(V_VISIBLE - 1);
  localparam logic [V_CNT_WID-1:0] VS_START   = V_CNT_WID'(V_VISIBLE + V_FRONT);
  localparam logic [V_CNT_WID-1:0] VS_END     = V_CNT_WID'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [H_CNT_WID-1:0] h_cnt;
  logic [V_CNT_WID-1:0] v_cnt;
  logic [V_CNT_WID-1:0] v_inc;
  logic                 h_wrap;
  logic                 h_blank;
  logic                 visible;
  logic                 hs_active;
  logic                 vs_active;

  assign h_wrap    = (h_cnt == H_LAST);
  assign h_blank   = (h_cnt >= H_VIS);
  assign v_inc     = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
  assign visible   = !h_blank && (v_cnt < V_VIS);
  assign hs_active = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_active = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // During horizontal blanking the engine is already told the next line so it can prefetch.
  assign pixIf_H_CNT      = h_cnt;
  assign pixIf_H_BLANKING = h_blank;
  assign pixIf_next_V_CNT = h_blank ? v_inc : v_cnt;
  assign pixIf_NEXT_FRAME = (h_cnt == H_VIS) && (v_cnt == V_VIS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_inc;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Colour and syncs share one register stage so they reach the pins on the same pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
      HSYNC <= ~HSYNC_POL;
      VSYNC <= ~VSYNC_POL;
    end else if (pix_en) begin
      vga_r <= visible ? pixIf_r : 4'h0;
      vga_g <= visible ? pixIf_g : 4'h0;
      vga_b <= visible ? pixIf_b : 4'h0;
      HSYNC <= hs_active ? HSYNC_POL : ~HSYNC_POL;
      VSYNC <= vs_active ? VSYNC_POL : ~VSYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller using a shrunken timing (15 x 8 scan,
// 8 x 4 visible) so whole frames, stalls and mid-frame reset fit in a short run.
module tb_vga_timing_controller;

  logic       clk;
  logic       rst_n;
  logic       pix_en;
  logic       nf;
  logic       blank;
  logic [3:0] h_cnt;
  logic [2:0] next_v;
  logic [3:0] eng_r, eng_g, eng_b;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       hsync, vsync;
  logic [11:0] colour;

  int passed = 0;
  int total  = 0;

  int hs_low, hs_pulses, vs_low, vs_pulses, nf_cnt, blank_cnt, colour_cnt;
  logic prev_hs, prev_vs;

  vga_timing_controller #(
    .H_CNT_WID(4), .V_CNT_WID(3),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_en(pix_en),
    .pixIf_NEXT_FRAME(nf),
    .pixIf_H_BLANKING(blank),
    .pixIf_H_CNT(h_cnt),
    .pixIf_next_V_CNT(next_v),
    .pixIf_r(eng_r),
    .pixIf_g(eng_g),
    .pixIf_b(eng_b),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .HSYNC(hsync),
    .VSYNC(vsync)
  );

  assign colour = {vga_r, vga_g, vga_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_colour(input logic [11:0] c);
    {eng_r, eng_g, eng_b} = c;
  endtask

  task automatic clear_stats();
    hs_low = 0; hs_pulses = 0; vs_low = 0; vs_pulses = 0;
    nf_cnt = 0; blank_cnt = 0; colour_cnt = 0;
    prev_hs = 1'b1; prev_vs = 1'b1;
  endtask

  // Sync edges appear one enabled cycle after the counter enters the sync region.
  task automatic sample();
    if (hsync == 1'b0) hs_low++;
    if (prev_hs == 1'b1 && hsync == 1'b0) begin
      hs_pulses++;
      check("hs_start_pos", h_cnt, 11);
    end
    prev_hs = hsync;
    if (vsync == 1'b0) vs_low++;
    if (prev_vs == 1'b1 && vsync == 1'b0) begin
      vs_pulses++;
      check("vs_start_h", h_cnt, 1);
      check("vs_start_line", next_v, 5);
    end
    prev_vs = vsync;
    if (nf) begin
      nf_cnt++;
      check("nf_next_v", next_v, 4);
    end
    if (blank) blank_cnt++;
    if (colour != 12'h000) colour_cnt++;
  endtask

  initial begin
    rst_n  = 1'b0;
    pix_en = 1'b0;
    set_colour(12'hABC);
    clear_stats();
    step();
    step();

    check("rst_h_cnt", h_cnt, 0);
    check("rst_next_v", next_v, 0);
    check("rst_blank", blank, 0);
    check("rst_nf", nf, 0);
    check("rst_colour", colour, 12'h000);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);

    // One full frame of enabled cycles; position after step k is k mod 120.
    rst_n  = 1'b1;
    pix_en = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      step();
      sample();
      if (k == 1) begin
        check("first_h_cnt", h_cnt, 1);
        check("first_colour", colour, 12'hABC);
        check("first_hsync", hsync, 1);
        check("first_vsync", vsync, 1);
      end
      if (k == 53) begin
        check("nf_at_8_3", nf, 1);
        check("nf_blank", blank, 1);
      end
      if (k == 113) check("last_line_wrap", next_v, 0);
    end
    check("frame_h_wrap", h_cnt, 0);
    check("frame_v_wrap", next_v, 0);
    check("hs_pulses", hs_pulses, 8);
    check("hs_low", hs_low, 24);
    check("vs_pulses", vs_pulses, 1);
    check("vs_low", vs_low, 30);
    check("nf_cycles", nf_cnt, 1);
    check("blank_cycles", blank_cnt, 56);
    check("colour_cycles", colour_cnt, 32);

    // Visible edge on pins: h=7 shows colour, h=8 is forced black.
    set_colour(12'hFFF);
    for (int k = 0; k < 8; k++) step();
    check("pin_h7", colour, 12'hFFF);
    step();
    check("pin_h8", colour, 12'h000);

    // Advance from (9,0) to (8,3) and stall there.
    for (int k = 0; k < 44; k++) step();
    check("pre_stall_nf", nf, 1);
    pix_en = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("stall_nf", nf, 1);
    check("stall_h_cnt", h_cnt, 8);
    check("stall_next_v", next_v, 4);
    check("stall_colour", colour, 12'hFFF);
    check("stall_hsync", hsync, 1);

    // Half-rate enable: one frame in 240 clocks, every width doubled.
    clear_stats();
    for (int i = 0; i < 240; i++) begin
      pix_en = (i % 2 == 0);
      step();
      sample();
    end
    check("half_h_cnt", h_cnt, 8);
    check("half_nf", nf, 1);
    check("half_hs_pulses", hs_pulses, 8);
    check("half_hs_low", hs_low, 48);
    check("half_vs_pulses", vs_pulses, 1);
    check("half_vs_low", vs_low, 60);
    check("half_nf_cycles", nf_cnt, 2);
    check("half_blank", blank_cnt, 112);
    check("half_colour", colour_cnt, 64);

    // Run into both sync pulses at (12,5), then reset asynchronously.
    pix_en = 1'b1;
    for (int k = 0; k < 34; k++) step();
    check("pre_rst_h_cnt", h_cnt, 12);
    check("pre_rst_hsync", hsync, 0);
    check("pre_rst_vsync", vsync, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_h_cnt", h_cnt, 0);
    check("arst_next_v", next_v, 0);
    check("arst_colour", colour, 12'h000);
    check("arst_hsync", hsync, 1);
    check("arst_vsync", vsync, 1);
    check("arst_blank", blank, 0);
    step();
    check("held_rst_h_cnt", h_cnt, 0);
    rst_n = 1'b1;
    step();
    check("restart_h_cnt", h_cnt, 1);
    check("restart_next_v", next_v, 0);
    check("restart_colour", colour, 12'hFFF);
    check("restart_hsync", hsync, 1);
    check("restart_vsync", vsync, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
